// File: rtl/stage_mem_access_if.sv
// stage_mem_access_if: req/ack data bus between the memory-access stage and memory
interface stage_mem_access_if #(parameter int AW = 32, parameter int DW = 32);
  logic mem_req;
  logic mem_we;
  logic [AW-1:0] mem_addr_o;
  logic [3:0] mem_sel;
  logic [DW-1:0] mem_wdata;
  logic mem_ack;
  logic [DW-1:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr_o, mem_sel, mem_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr_o, mem_sel, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/stage_mem_access.sv
// stage_mem_access: MEM pipeline stage doing lane-steered loads/stores over a req/ack bus.
// Define MEM_MISALIGN_EXC_EN to trap misaligned halfword/word accesses instead of truncating them.
module stage_mem_access #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int OPW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic [OPW-1:0] aluop_i,
  input  logic [4:0] reg_waddr_i,
  input  logic we_i,
  input  logic [DW-1:0] reg_wdata_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] rt_data_i,
  stage_mem_access_if.master bus,
  output logic valid_o,
  output logic [4:0] reg_waddr_o,
  output logic we_o,
  output logic [DW-1:0] reg_wdata_o,
  output logic stallreq_o,
  output logic misalign_o,
  output logic [AW-1:0] badaddr_o
);
  localparam logic [OPW-1:0] LB  = OPW'(8'b11100000);
  localparam logic [OPW-1:0] LH  = OPW'(8'b11100001);
  localparam logic [OPW-1:0] LW  = OPW'(8'b11100011);
  localparam logic [OPW-1:0] LBU = OPW'(8'b11100100);
  localparam logic [OPW-1:0] LHU = OPW'(8'b11100101);
  localparam logic [OPW-1:0] SB  = OPW'(8'b11101000);
  localparam logic [OPW-1:0] SH  = OPW'(8'b11101001);
  localparam logic [OPW-1:0] SW  = OPW'(8'b11101011);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic is_ld, is_st, sx, mis, go, ld_q, sx_q;
  logic [1:0] sz, sz_q, lo_q;
  logic [3:0] sel;
  logic [15:0] sh;
  logic [DW-1:0] wd, ld_val;
  always_comb begin
    is_ld = aluop_i inside {LB, LBU, LH, LHU, LW};
    is_st = aluop_i inside {SB, SH, SW};
    sz = (aluop_i inside {LB, LBU, SB}) ? 2'd0 : (aluop_i inside {LH, LHU, SH}) ? 2'd1 : 2'd2;
    sx = aluop_i inside {LB, LH};
`ifdef MEM_MISALIGN_EXC_EN
    mis = (is_ld || is_st) && (sz == 2'd1 ? mem_addr_i[0] : (sz == 2'd2 && mem_addr_i[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    go = valid_i && (is_ld || is_st) && !mis;
    sel = sz == 2'd0 ? 4'b0001 << mem_addr_i[1:0] : sz == 2'd1 ? (mem_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = !is_st ? '0 : sz == 2'd0 ? {4{rt_data_i[7:0]}} : sz == 2'd1 ? {2{rt_data_i[15:0]}} : rt_data_i;
    sh = 16'(bus.mem_rdata >> {lo_q, 3'b000});
    ld_val = sz_q == 2'd0 ? {{24{sx_q & sh[7]}}, sh[7:0]} :
             sz_q == 2'd1 ? {{16{sx_q & sh[15]}}, sh[15:0]} : bus.mem_rdata;
    state_n = rst ? IDLE : state == IDLE ? (go ? WAIT : IDLE) : (bus.mem_ack ? IDLE : WAIT);
    stallreq_o = !rst && (state == IDLE ? go : !bus.mem_ack);
  end
  always_ff @(posedge clk) state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.mem_sel <= '0;
      bus.mem_wdata <= '0;
      valid_o <= 1'b0;
      reg_waddr_o <= '0;
      we_o <= 1'b0;
      reg_wdata_o <= '0;
      ld_q <= 1'b0;
      sx_q <= 1'b0;
      sz_q <= '0;
      lo_q <= '0;
    end else if (state == IDLE) begin
      if (!valid_i) begin
        valid_o <= 1'b0;
        we_o <= 1'b0;
      end else if (go) begin
        bus.mem_req <= 1'b1;
        bus.mem_we <= is_st;
        bus.mem_addr_o <= {mem_addr_i[AW-1:2], 2'b00};
        bus.mem_sel <= sel;
        bus.mem_wdata <= wd;
        valid_o <= 1'b0;
        reg_waddr_o <= reg_waddr_i;
        we_o <= we_i;
        reg_wdata_o <= reg_wdata_i;
        ld_q <= is_ld;
        sx_q <= sx;
        sz_q <= sz;
        // byte offset of the addressed item once truncated to its natural alignment
        lo_q <= mem_addr_i[1:0] & (sz == 2'd0 ? 2'b11 : sz == 2'd1 ? 2'b10 : 2'b00);
      end else begin
        valid_o <= 1'b1;
        reg_waddr_o <= reg_waddr_i;
        we_o <= we_i && !mis;
        reg_wdata_o <= reg_wdata_i;
      end
    end else if (bus.mem_ack) begin
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      valid_o <= 1'b1;
      if (ld_q) reg_wdata_o <= ld_val;
    end
  end
`ifdef MEM_MISALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_o <= 1'b0;
      badaddr_o <= '0;
    end else begin
      misalign_o <= state == IDLE && valid_i && mis;
      if (state == IDLE && valid_i && mis) badaddr_o <= mem_addr_i;
    end
  end
`else
  assign misalign_o = 1'b0;
  assign badaddr_o = '0;
`endif
endmodule

// File: tb/tb_stage_mem_access.sv
// tb_stage_mem_access: directed table, corner sequences and randomized ops against a byte-level model.
module tb_stage_mem_access;
  localparam logic [7:0] EXE_LB = 8'b11100000, EXE_LH = 8'b11100001, EXE_LW = 8'b11100011;
  localparam logic [7:0] EXE_LBU = 8'b11100100, EXE_LHU = 8'b11100101;
  localparam logic [7:0] EXE_SB = 8'b11101000, EXE_SH = 8'b11101001, EXE_SW = 8'b11101011;
  localparam logic [7:0] EXE_OR = 8'b00100101;

  typedef struct {
    logic [7:0] op;
    logic [31:0] addr, rt, wdin, rdata;
    logic we;
    int waits;
    logic [3:0] sel;
    logic [31:0] wdata;
    logic mwe;
    logic [31:0] res;
  } vec_t;

  logic clk = 0, rst = 1, valid_i = 0, we_i = 0;
  logic [7:0] aluop_i = 0;
  logic [4:0] reg_waddr_i = 0;
  logic [31:0] reg_wdata_i = 0, mem_addr_i = 0, rt_data_i = 0;
  logic valid_o, we_o, stallreq_o, misalign_o;
  logic [4:0] reg_waddr_o;
  logic [31:0] reg_wdata_o, badaddr_o;
  int checks = 0, errors = 0;
  vec_t tbl[10];
  vec_t v;
  logic [7:0] ops[9] = '{EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU, EXE_SB, EXE_SH, EXE_SW, EXE_OR};

  stage_mem_access_if #(.AW(32), .DW(32)) bus();

  stage_mem_access dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .reg_waddr_i(reg_waddr_i),
    .we_i(we_i), .reg_wdata_i(reg_wdata_i), .mem_addr_i(mem_addr_i), .rt_data_i(rt_data_i),
    .bus(bus), .valid_o(valid_o), .reg_waddr_o(reg_waddr_o), .we_o(we_o),
    .reg_wdata_o(reg_wdata_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o), .badaddr_o(badaddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: item of n bytes at the naturally-aligned offset within the word
  function automatic void model(input logic [7:0] op, input logic [31:0] addr, rt, rdata,
                                output logic ld, output logic mis, output logic [3:0] sel,
                                output logic [31:0] wdata, output logic [31:0] res);
    int n, off, eff;
    logic [31:0] mask;
    n = (op == EXE_LB || op == EXE_LBU || op == EXE_SB) ? 1 :
        (op == EXE_LH || op == EXE_LHU || op == EXE_SH) ? 2 : 4;
    ld = op inside {EXE_LB, EXE_LH, EXE_LW, EXE_LBU, EXE_LHU};
    off = int'(addr % 4);
    mis = (off % n) != 0;
    eff = off - off % n;
    sel = 4'((32'd1 << n) - 1) << eff;
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
    wdata = 0;
    if (!ld) for (int i = 0; i < 4 / n; i++) wdata |= (rt & mask) << (8 * n * i);
    res = (rdata >> (8 * eff)) & mask;
    if ((op == EXE_LB || op == EXE_LH) && res[8 * n - 1]) res |= ~mask;
  endfunction

  task automatic mem_op(input string nm, input vec_t x);
    int st = 0;
    valid_i = 1; aluop_i = x.op; mem_addr_i = x.addr; rt_data_i = x.rt;
    reg_wdata_i = x.wdin; we_i = x.we; reg_waddr_i = 5'd9;
    #1;
    if (stallreq_o) st++;
    step();
    chk({nm, " req"}, 32'(bus.mem_req), 1);
    chk({nm, " mem_we"}, 32'(bus.mem_we), 32'(x.mwe));
    chk({nm, " addr"}, bus.mem_addr_o, x.addr & ~32'd3);
    chk({nm, " sel"}, 32'(bus.mem_sel), 32'(x.sel));
    chk({nm, " wdata"}, bus.mem_wdata, x.wdata);
    chk({nm, " valid_wait"}, 32'(valid_o), 0);
    for (int k = 0; k < x.waits; k++) begin
      if (stallreq_o) st++;
      bus.mem_rdata = $urandom;
      step();
    end
    chk({nm, " addr_hold"}, bus.mem_addr_o, x.addr & ~32'd3);
    bus.mem_ack = 1; bus.mem_rdata = x.rdata;
    #1;
    if (stallreq_o) st++;
    chk({nm, " stall_cycles"}, 32'(st), 32'(x.waits + 1));
    step();
    bus.mem_ack = 0; bus.mem_rdata = $urandom; valid_i = 0;
    chk({nm, " valid"}, 32'(valid_o), 1);
    chk({nm, " we_o"}, 32'(we_o), 32'(x.we));
    chk({nm, " waddr"}, 32'(reg_waddr_o), 9);
    chk({nm, " result"}, reg_wdata_o, x.res);
    chk({nm, " req_drop"}, 32'(bus.mem_req), 0);
    chk({nm, " mem_we_drop"}, 32'(bus.mem_we), 0);
  endtask

  task automatic nm_op(input string nm, input logic [4:0] wa, input logic wen, input logic [31:0] wd);
    valid_i = 1; aluop_i = EXE_OR; reg_waddr_i = wa; we_i = wen; reg_wdata_i = wd;
    #1;
    chk({nm, " stall"}, 32'(stallreq_o), 0);
    step();
    valid_i = 0;
    chk({nm, " valid"}, 32'(valid_o), 1);
    chk({nm, " we_o"}, 32'(we_o), 32'(wen));
    chk({nm, " waddr"}, 32'(reg_waddr_o), 32'(wa));
    chk({nm, " wdata"}, reg_wdata_o, wd);
    chk({nm, " no_req"}, 32'(bus.mem_req), 0);
  endtask

`ifdef MEM_MISALIGN_EXC_EN
  task automatic mis_op(input string nm, input logic [7:0] op, input logic [31:0] addr);
    valid_i = 1; aluop_i = op; mem_addr_i = addr; we_i = 1;
    #1;
    chk({nm, " stall"}, 32'(stallreq_o), 0);
    step();
    valid_i = 0;
    chk({nm, " req"}, 32'(bus.mem_req), 0);
    chk({nm, " misalign"}, 32'(misalign_o), 1);
    chk({nm, " badaddr"}, badaddr_o, addr);
    chk({nm, " valid"}, 32'(valid_o), 1);
    chk({nm, " we_o"}, 32'(we_o), 0);
    step();
    chk({nm, " misalign_pulse"}, 32'(misalign_o), 0);
    chk({nm, " req_after"}, 32'(bus.mem_req), 0);
  endtask
`endif

  initial begin
    logic ld, mis;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    tbl[0] = '{op:EXE_LB,  addr:32'h1003, rt:0, wdin:0, rdata:32'h80FF_FF00, we:1, waits:3, sel:4'b1000, wdata:0, mwe:0, res:32'hFFFF_FF80};
    tbl[1] = '{op:EXE_LBU, addr:32'h1003, rt:0, wdin:0, rdata:32'h80FF_FF00, we:1, waits:1, sel:4'b1000, wdata:0, mwe:0, res:32'h0000_0080};
    tbl[2] = '{op:EXE_SH,  addr:32'h2002, rt:32'hAAAA_5678, wdin:32'hDEAD_0001, rdata:0, we:0, waits:0, sel:4'b1100, wdata:32'h5678_5678, mwe:1, res:32'hDEAD_0001};
    tbl[3] = '{op:EXE_LH,  addr:32'h2000, rt:0, wdin:0, rdata:32'h1234_8001, we:1, waits:0, sel:4'b0011, wdata:0, mwe:0, res:32'hFFFF_8001};
    tbl[4] = '{op:EXE_LHU, addr:32'h2002, rt:0, wdin:0, rdata:32'h9ABC_0000, we:1, waits:2, sel:4'b1100, wdata:0, mwe:0, res:32'h0000_9ABC};
    tbl[5] = '{op:EXE_SB,  addr:32'h4001, rt:32'h0000_00A5, wdin:32'h55, rdata:0, we:0, waits:1, sel:4'b0010, wdata:32'hA5A5_A5A5, mwe:1, res:32'h55};
    tbl[6] = '{op:EXE_SW,  addr:32'h4004, rt:32'h1122_3344, wdin:32'h66, rdata:0, we:0, waits:0, sel:4'b1111, wdata:32'h1122_3344, mwe:1, res:32'h66};
    tbl[7] = '{op:EXE_LW,  addr:32'h5008, rt:0, wdin:0, rdata:32'hCAFE_BABE, we:1, waits:0, sel:4'b1111, wdata:0, mwe:0, res:32'hCAFE_BABE};
    tbl[8] = '{op:EXE_LB,  addr:32'h1000, rt:0, wdin:0, rdata:32'h0000_007F, we:1, waits:0, sel:4'b0001, wdata:0, mwe:0, res:32'h0000_007F};
    tbl[9] = '{op:EXE_LW,  addr:32'h3001, rt:0, wdin:0, rdata:32'h0BAD_F00D, we:1, waits:0, sel:4'b1111, wdata:0, mwe:0, res:32'h0BAD_F00D};

    valid_i = 1; aluop_i = EXE_LW;
    step();
    chk("reset stall", 32'(stallreq_o), 0);
    step();
    chk("reset req", 32'(bus.mem_req), 0);
    chk("reset mem_we", 32'(bus.mem_we), 0);
    chk("reset addr", bus.mem_addr_o, 0);
    chk("reset sel", 32'(bus.mem_sel), 0);
    chk("reset wdata", bus.mem_wdata, 0);
    chk("reset valid", 32'(valid_o), 0);
    chk("reset waddr", 32'(reg_waddr_o), 0);
    chk("reset we_o", 32'(we_o), 0);
    chk("reset result", reg_wdata_o, 0);
    chk("reset misalign", 32'(misalign_o), 0);
    chk("reset badaddr", badaddr_o, 0);
    rst = 0; valid_i = 0;
    step();

    nm_op("nonmem", 5'd5, 1'b1, 32'h1234);
    step();
    chk("idle valid", 32'(valid_o), 0);
    chk("idle we_o", 32'(we_o), 0);

    for (int i = 0; i < 9; i++) begin
      mem_op($sformatf("vec%0d", i), tbl[i]);
      step();
    end

    mem_op("b2b lw", tbl[7]);
    nm_op("b2b follow", 5'd3, 1'b1, 32'h77);
    step();
    chk("b2b idle valid", 32'(valid_o), 0);

    valid_i = 1; aluop_i = EXE_LW; mem_addr_i = 32'h6000; we_i = 1; reg_waddr_i = 5'd7;
    step();
    chk("rstwait req", 32'(bus.mem_req), 1);
    rst = 1;
    #1;
    chk("rstwait stall", 32'(stallreq_o), 0);
    step();
    rst = 0; valid_i = 0;
    chk("rstwait req_drop", 32'(bus.mem_req), 0);
    chk("rstwait addr", bus.mem_addr_o, 0);
    chk("rstwait sel", 32'(bus.mem_sel), 0);
    chk("rstwait valid", 32'(valid_o), 0);
    chk("rstwait we_o", 32'(we_o), 0);
    chk("rstwait waddr", 32'(reg_waddr_o), 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
    #1;
    chk("stray ack stall", 32'(stallreq_o), 0);
    step();
    bus.mem_ack = 0;
    chk("stray ack valid", 32'(valid_o), 0);
    chk("stray ack result", reg_wdata_o, 0);
    step();
    chk("stray ack valid2", 32'(valid_o), 0);

`ifdef MEM_MISALIGN_EXC_EN
    mis_op("misalign lw", EXE_LW, 32'h3001);
`else
    mem_op("trunc lw", tbl[9]);
`endif
    step();

    for (int i = 0; i < 60; i++) begin
      v.op = ops[$urandom_range(0, 8)];
      v.addr = $urandom; v.rt = $urandom; v.rdata = $urandom; v.wdin = $urandom;
      v.waits = $urandom_range(0, 3);
      if (v.op == EXE_OR) nm_op($sformatf("rnd%0d nonmem", i), 5'($urandom), 1'($urandom), v.wdin);
      else begin
        model(v.op, v.addr, v.rt, v.rdata, ld, mis, v.sel, v.wdata, v.res);
        v.we = ld; v.mwe = !ld;
        if (!ld) v.res = v.wdin;
`ifdef MEM_MISALIGN_EXC_EN
        if (mis) mis_op($sformatf("rnd%0d mis", i), v.op, v.addr);
        else mem_op($sformatf("rnd%0d", i), v);
`else
        mem_op($sformatf("rnd%0d", i), v);
`endif
      end
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_mem_access.md
Name: stage_mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's write-back intent, result data, memory address, ALU op and store data.
- Performs loads and stores over a req/ack data bus, with byte-lane steering and load sign/zero extension.
- Presents registered write-back results to the next pipeline stage and raises a stall request while a bus transaction is outstanding.

Parameters:
- DW, 32, data/register width (fixed 32; byte lanes assume 4 bytes)
- AW, 32, memory address width
- OPW, 8, ALU-op width (matches `AluOpBus)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- valid_i  input  1  upstream instruction valid
- aluop_i  input  OPW  ALU op from execute stage
- reg_waddr_i  input  5  destination register
- we_i  input  1  register write enable
- reg_wdata_i  input  DW  execute result (non-load write data)
- mem_addr_i  input  AW  effective address
- rt_data_i  input  DW  store data
- mem_req  output  1  bus request
- mem_we  output  1  bus write
- mem_addr_o  output  AW  word-aligned bus address, {mem_addr_i[AW-1:2],2'b00}
- mem_sel  output  4  byte enables, bit n = byte lane n (little-endian)
- mem_wdata  output  DW  lane-replicated store data
- mem_ack  input  1  bus completion, one cycle
- mem_rdata  input  DW  read data, valid with mem_ack
- valid_o  output  1  result valid to next stage
- reg_waddr_o  output  5  registered destination
- we_o  output  1  registered write enable
- reg_wdata_o  output  DW  registered write data
- stallreq_o  output  1  combinational stall to pipeline controller
- misalign_o  output  1  misaligned-access exception pulse
- badaddr_o  output  AW  faulting address

Behaviour:
- Ops decoded from defines.v:
  - loads: `EXE_LB_OP, `EXE_LH_OP, `EXE_LW_OP, `EXE_LBU_OP, `EXE_LHU_OP
  - stores: `EXE_SB_OP, `EXE_SH_OP, `EXE_SW_OP
  - any other value is a non-memory op.
- Reset: state IDLE. mem_req, mem_we, mem_addr_o, mem_sel, mem_wdata, valid_o, reg_waddr_o, we_o, reg_wdata_o, misalign_o, badaddr_o are all 0. stallreq_o is 0 while rst is high.
- FSM states: IDLE, WAIT.
- IDLE, valid_i=0: next cycle valid_o=0, we_o=0, other outputs hold.
- IDLE, valid_i=1, non-memory op: 1-cycle latency. Next edge registers valid_o=1, reg_waddr_i, we_i and reg_wdata_i.
- IDLE, valid_i=1, memory op:
  - stallreq_o=1 combinationally in the same cycle.
  - Next edge enters WAIT and registers mem_req=1 plus mem_we, mem_addr_o, mem_sel, mem_wdata, destination and we.
  - valid_o=0 while in WAIT.
- WAIT:
  - Bus outputs are held stable until mem_ack.
  - Inputs are ignored; upstream holds them because of the stall.
  - stallreq_o = !mem_ack.
  - On mem_ack: next edge drops mem_req/mem_we to 0, returns to IDLE, and registers valid_o=1.
  - Loads: reg_wdata_o = formatted mem_rdata.
  - Stores: we_o = we_i (0 by decode), reg_wdata_o = reg_wdata_i.
- Minimum memory-op latency: 2 cycles, when ack arrives in the first WAIT cycle. No upper bound.
- Store lanes:
  - SB: sel = 1<<addr[1:0]; wdata = {4{rt[7:0]}}.
  - SH: sel = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rt[15:0]}}.
  - SW: sel = 4'b1111; wdata = rt.
- Loads: mem_sel as for stores of the same size, mem_wdata=0.
  - Byte loads select the lane given by addr[1:0].
  - Halfword loads select the half given by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_ack while in IDLE is ignored.
- rst asserted in WAIT: abandons the transaction and drops mem_req next edge. A late ack after that is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_EXC_EN.
- Defined:
  - A halfword op with addr[0]=1 is misaligned; a word op with addr[1:0]!=0 is misaligned.
  - On a misaligned op: no bus request, no stall. Next edge sets misalign_o=1 for one cycle, badaddr_o=mem_addr_i, valid_o=1, we_o=0.
- Undefined:
  - Offending low address bits are treated as 0 (halfword uses addr[1]; word uses lane 0).
  - misalign_o and badaddr_o are tied to 0.

Test Plan:
- Non-memory op, reg_waddr_i=5, we_i=1, reg_wdata_i=0x1234 -> next cycle valid_o=1, we_o=1, reg_wdata_o=0x1234; stallreq_o stays 0.
- LB at addr 0x1003, ack after 3 WAIT cycles with mem_rdata=0x80FF_FF00:
  - mem_addr_o=0x1000, mem_sel=4'b1000.
  - stallreq_o high for 4 cycles.
  - reg_wdata_o=0xFFFF_FF80.
  - LBU at the same address and data -> 0x0000_0080.
- SH at addr 0x2002, rt_data_i=0xAAAA_5678, ack on first WAIT cycle -> mem_we=1, mem_sel=4'b1100, mem_wdata=0x5678_5678, total latency 2 cycles, we_o=0.
- LW back-to-back with non-memory op -> LW result appears on ack+1, the following op 1 cycle later; no lost or duplicated valid_o.
- rst pulse during WAIT -> mem_req=0 and all outputs 0 next edge; a subsequent stray mem_ack produces no valid_o.
- With MEM_MISALIGN_EXC_EN, LW at 0x3001 -> mem_req never asserts, misalign_o=1 one cycle, badaddr_o=0x3001. Without the macro -> bus access at 0x3000 with sel=4'b1111.
